// File: rtl/axi_lite_pkg.sv
// Shared types and constants for the AXI4-Lite command-port initiator.
package axi_lite_pkg;

    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;

    localparam int unsigned DEFAULT_TIMEOUT = 1024;

    typedef enum logic [2:0] {
        IDLE,
        WR_REQ,
        WR_RESP,
        RD_REQ,
        RD_DATA,
        RSP
    } state_t;

endpackage

// File: rtl/axi_lite_watchdog.sv
// Per-state wait counter; expired asserts in the C_TIMEOUT-th enabled cycle.
module axi_lite_watchdog
    import axi_lite_pkg::*;
#(
    parameter int unsigned C_TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int unsigned CW = (C_TIMEOUT > 2) ? $clog2(C_TIMEOUT) : 1;

    logic [CW-1:0] count;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (en && !expired) begin
            count <= count + CW'(1);
        end
    end

    assign expired = en && (count == CW'(C_TIMEOUT - 1));

endmodule

// File: rtl/axi_lite_master.sv
// Single-outstanding AXI4-Lite initiator driven by a valid/ready command port.
module axi_lite_master
    import axi_lite_pkg::*;
#(
    parameter int unsigned C_AXI_DATA_WIDTH = 32,
    parameter int unsigned C_AXI_ADDR_WIDTH = 32,
    parameter int unsigned C_TIMEOUT        = DEFAULT_TIMEOUT
) (
    input  logic                          axi_aclk,
    input  logic                          axi_areset,
    input  logic                          cmd_valid,
    output logic                          cmd_ready,
    input  logic                          cmd_write,
    input  logic [C_AXI_ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [C_AXI_DATA_WIDTH-1:0]   cmd_wdata,
    input  logic [C_AXI_DATA_WIDTH/8-1:0] cmd_wstrb,
    output logic                          rsp_valid,
    input  logic                          rsp_ready,
    output logic [C_AXI_DATA_WIDTH-1:0]   rsp_rdata,
    output logic [1:0]                    rsp_resp,
    output logic                          rsp_timeout,
    output logic [C_AXI_ADDR_WIDTH-1:0]   axi_awaddr,
    output logic                          axi_awvalid,
    input  logic                          axi_awready,
    output logic [C_AXI_DATA_WIDTH-1:0]   axi_wdata,
    output logic [C_AXI_DATA_WIDTH/8-1:0] axi_wstrb,
    output logic                          axi_wvalid,
    input  logic                          axi_wready,
    input  logic [1:0]                    axi_bresp,
    input  logic                          axi_bvalid,
    output logic                          axi_bready,
    output logic [C_AXI_ADDR_WIDTH-1:0]   axi_araddr,
    output logic                          axi_arvalid,
    input  logic                          axi_arready,
    input  logic [C_AXI_DATA_WIDTH-1:0]   axi_rdata,
    input  logic [1:0]                    axi_rresp,
    input  logic                          axi_rvalid,
    output logic                          axi_rready
);

    state_t state, state_next;
    logic   aw_done, w_done, aw_done_next, w_done_next;
    logic   awvalid_next, wvalid_next, bready_next, arvalid_next, rready_next;
    logic   cmd_ready_next, rsp_valid_next, rsp_timeout_next, load;
    logic   [C_AXI_DATA_WIDTH-1:0] rsp_rdata_next;
    logic   [1:0] rsp_resp_next;
    logic   wd_expired, wd_en;

    assign wd_en = (state == WR_REQ) || (state == WR_RESP) ||
                   (state == RD_REQ) || (state == RD_DATA);

    axi_lite_watchdog #(.C_TIMEOUT(C_TIMEOUT)) u_watchdog (
        .clk     (axi_aclk),
        .rst     (axi_areset),
        .clr     (state_next != state),
        .en      (wd_en),
        .expired (wd_expired)
    );

    always_comb begin
        state_next       = state;
        aw_done_next     = aw_done;
        w_done_next      = w_done;
        awvalid_next     = axi_awvalid;
        wvalid_next      = axi_wvalid;
        bready_next      = axi_bready;
        arvalid_next     = axi_arvalid;
        rready_next      = axi_rready;
        rsp_valid_next   = rsp_valid;
        rsp_rdata_next   = rsp_rdata;
        rsp_resp_next    = rsp_resp;
        rsp_timeout_next = rsp_timeout;
        load             = 1'b0;
        case (state)
            IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    load         = 1'b1;
                    aw_done_next = 1'b0;
                    w_done_next  = 1'b0;
                    if (cmd_write) begin
                        state_next   = WR_REQ;
                        awvalid_next = 1'b1;
                        wvalid_next  = 1'b1;
                    end else begin
                        state_next   = RD_REQ;
                        arvalid_next = 1'b1;
                    end
                end
            end
            WR_REQ: begin
                if (axi_awvalid && axi_awready) begin
                    awvalid_next = 1'b0;
                    aw_done_next = 1'b1;
                end
                if (axi_wvalid && axi_wready) begin
                    wvalid_next = 1'b0;
                    w_done_next = 1'b1;
                end
                if (aw_done_next && w_done_next) begin
                    state_next  = WR_RESP;
                    bready_next = 1'b1;
                end
            end
            WR_RESP: begin
                if (axi_bvalid && axi_bready) begin
                    bready_next      = 1'b0;
                    rsp_valid_next   = 1'b1;
                    rsp_rdata_next   = '0;
                    rsp_resp_next    = axi_bresp;
                    rsp_timeout_next = 1'b0;
                    state_next       = RSP;
                end
            end
            RD_REQ: begin
                if (axi_arvalid && axi_arready) begin
                    arvalid_next = 1'b0;
                    rready_next  = 1'b1;
                    state_next   = RD_DATA;
                end
            end
            RD_DATA: begin
                if (axi_rvalid && axi_rready) begin
                    rready_next      = 1'b0;
                    rsp_valid_next   = 1'b1;
                    rsp_rdata_next   = axi_rdata;
                    rsp_resp_next    = axi_rresp;
                    rsp_timeout_next = 1'b0;
                    state_next       = RSP;
                end
            end
            RSP: begin
                if (rsp_ready) begin
                    rsp_valid_next = 1'b0;
                    state_next     = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
        // Watchdog abort overrides any handshake landing in the same cycle.
        if (wd_expired) begin
            awvalid_next     = 1'b0;
            wvalid_next      = 1'b0;
            bready_next      = 1'b0;
            arvalid_next     = 1'b0;
            rready_next      = 1'b0;
            rsp_valid_next   = 1'b1;
            rsp_rdata_next   = '0;
            rsp_resp_next    = SLVERR;
            rsp_timeout_next = 1'b1;
            state_next       = RSP;
        end
        cmd_ready_next = (state_next == IDLE);
    end

    always_ff @(posedge axi_aclk) begin
        if (axi_areset) begin
            state       <= IDLE;
            aw_done     <= 1'b0;
            w_done      <= 1'b0;
            cmd_ready   <= 1'b0;
            axi_awvalid <= 1'b0;
            axi_wvalid  <= 1'b0;
            axi_bready  <= 1'b0;
            axi_arvalid <= 1'b0;
            axi_rready  <= 1'b0;
            axi_awaddr  <= '0;
            axi_wdata   <= '0;
            axi_wstrb   <= '0;
            axi_araddr  <= '0;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_resp    <= '0;
            rsp_timeout <= 1'b0;
        end else begin
            state       <= state_next;
            aw_done     <= aw_done_next;
            w_done      <= w_done_next;
            cmd_ready   <= cmd_ready_next;
            axi_awvalid <= awvalid_next;
            axi_wvalid  <= wvalid_next;
            axi_bready  <= bready_next;
            axi_arvalid <= arvalid_next;
            axi_rready  <= rready_next;
            rsp_valid   <= rsp_valid_next;
            rsp_rdata   <= rsp_rdata_next;
            rsp_resp    <= rsp_resp_next;
            rsp_timeout <= rsp_timeout_next;
            if (load) begin
                if (cmd_write) begin
                    axi_awaddr <= cmd_addr;
                    axi_wdata  <= cmd_wdata;
                    axi_wstrb  <= cmd_wstrb;
                end else begin
                    axi_araddr <= cmd_addr;
                end
            end
        end
    end

endmodule

// File: tb/tb_axi_lite_master.sv
// Directed bench: adder-style slave model plus response scoreboard.
module tb_axi_lite_master;
    import axi_lite_pkg::*;

    localparam int unsigned DW = 32;
    localparam int unsigned AW = 32;
    localparam int unsigned TO = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic          cmd_valid, cmd_ready, cmd_write, rsp_valid, rsp_ready, rsp_timeout;
    logic [AW-1:0] cmd_addr, axi_awaddr, axi_araddr;
    logic [DW-1:0] cmd_wdata, rsp_rdata, axi_wdata;
    logic [DW-1:0] axi_rdata = '0;
    logic [3:0]    cmd_wstrb, axi_wstrb;
    logic [1:0]    rsp_resp;
    logic          axi_awvalid, axi_awready, axi_wvalid, axi_wready, axi_bready;
    logic          axi_arvalid, axi_arready, axi_rready;
    logic          axi_bvalid = 1'b0;
    logic          axi_rvalid = 1'b0;

    axi_lite_master #(
        .C_AXI_DATA_WIDTH(DW),
        .C_AXI_ADDR_WIDTH(AW),
        .C_TIMEOUT(TO)
    ) dut (
        .axi_aclk(clk), .axi_areset(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_resp(rsp_resp), .rsp_timeout(rsp_timeout),
        .axi_awaddr(axi_awaddr), .axi_awvalid(axi_awvalid), .axi_awready(axi_awready),
        .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb), .axi_wvalid(axi_wvalid),
        .axi_wready(axi_wready), .axi_bresp(2'b00), .axi_bvalid(axi_bvalid),
        .axi_bready(axi_bready), .axi_araddr(axi_araddr), .axi_arvalid(axi_arvalid),
        .axi_arready(axi_arready), .axi_rdata(axi_rdata), .axi_rresp(2'b00),
        .axi_rvalid(axi_rvalid), .axi_rready(axi_rready)
    );

    typedef struct {
        logic [31:0] rdata;
        logic [1:0]  resp;
        logic        timeout;
        bit          chk_data;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    int unsigned cyc = 0, last_rsp_cyc = 0, accept_cyc = 0;
    int unsigned rsp_count = 0, exp_count = 0;
    logic [31:0] last_rdata = '0;

    // Slave model: 0x00/0x04 operands, 0x08 start, 0x0C status, 0x10 sum.
    int unsigned aw_lat = 0, w_lat = 0, r_lat = 0;
    bit          b_never = 0;
    int unsigned aw_wait = 0, w_wait = 0, r_wait = 0, aw_hs_n = 0, w_hs_n = 0;
    int unsigned busy = 0;
    bit          started = 0;
    logic        have_aw = 1'b0, have_w = 1'b0;
    logic [31:0] s_addr = '0, s_data = '0;
    logic [31:0] mem [0:7];

    assign axi_awready = (aw_wait >= aw_lat);
    assign axi_wready  = (w_wait >= w_lat);
    assign axi_arready = 1'b1;

    function automatic logic [31:0] slave_read(input logic [31:0] addr);
        case (addr[4:2])
            3'd3:    return (started && busy == 0) ? 32'hFFFF_FFFF : 32'h0;
            3'd4:    return mem[0] + mem[1];
            default: return mem[addr[4:2]];
        endcase
    endfunction

    always @(posedge clk) begin : slave_proc
        logic [31:0] a, d;
        logic ga, gw;
        if (rst) begin
            aw_wait <= 0; w_wait <= 0; r_wait <= 0;
            have_aw <= 1'b0; have_w <= 1'b0;
            axi_bvalid <= 1'b0; axi_rvalid <= 1'b0;
        end else begin
            ga = have_aw; gw = have_w; a = s_addr; d = s_data;
            if (busy != 0) busy <= busy - 1;
            if (axi_awvalid && axi_awready) begin
                ga = 1'b1; a = axi_awaddr; aw_wait <= 0; aw_hs_n <= aw_hs_n + 1;
            end else if (axi_awvalid) begin
                aw_wait <= aw_wait + 1;
            end
            if (axi_wvalid && axi_wready) begin
                gw = 1'b1; d = axi_wdata; w_wait <= 0; w_hs_n <= w_hs_n + 1;
            end else if (axi_wvalid) begin
                w_wait <= w_wait + 1;
            end
            if (ga && gw) begin
                mem[a[4:2]] <= d;
                if (a[4:2] == 3'd2) begin busy <= 3; started <= 1; end
                if (!b_never) axi_bvalid <= 1'b1;
                ga = 1'b0; gw = 1'b0;
            end
            have_aw <= ga; have_w <= gw; s_addr <= a; s_data <= d;
            if (axi_bvalid && axi_bready) axi_bvalid <= 1'b0;
            if (axi_arvalid && axi_arready) begin
                axi_rdata <= slave_read(axi_araddr);
                if (r_lat == 0) axi_rvalid <= 1'b1;
                else r_wait <= r_lat;
            end
            if (r_wait != 0) begin
                r_wait <= r_wait - 1;
                if (r_wait == 1) axi_rvalid <= 1'b1;
            end
            if (axi_rvalid && axi_rready) axi_rvalid <= 1'b0;
        end
    end

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rsp_valid && rsp_ready) last_rsp_cyc <= cyc + 1;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic finish_sim();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    endtask

    function automatic exp_t mk(input logic [31:0] d, input logic [1:0] r, input logic t, input bit c);
        exp_t e;
        e.rdata = d; e.resp = r; e.timeout = t; e.chk_data = c;
        return e;
    endfunction

    always @(negedge clk) begin : monitor
        exp_t e;
        if (!rst && rsp_valid && rsp_ready) begin
            if (sb.size() == 0) begin
                checks++; errors++;
                $error("FAIL rsp_unexpected observed=%0h expected=none", rsp_rdata);
            end else begin
                e = sb.pop_front();
                check("rsp_resp", 64'(rsp_resp), 64'(e.resp));
                check("rsp_timeout", 64'(rsp_timeout), 64'(e.timeout));
                if (e.chk_data) check("rsp_rdata", 64'(rsp_rdata), 64'(e.rdata));
            end
            last_rdata = rsp_rdata;
            rsp_count++;
        end
    end

    task automatic send(input bit wr, input logic [31:0] addr, input logic [31:0] data,
                        input bit push, input exp_t e);
        int unsigned n = 0;
        if (push) begin sb.push_back(e); exp_count++; end
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = data; cmd_wstrb = '1;
        @(negedge clk);
        while (!cmd_ready) begin
            n++;
            if (n > 300) begin
                checks++; errors++;
                $error("FAIL cmd_accept observed=no_accept expected=accept");
                finish_sim();
            end
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        accept_cyc = cyc;
    endtask

    task automatic wait_rsp();
        int unsigned n = 0;
        while (rsp_count < exp_count) begin
            n++;
            if (n > 300) begin
                checks++; errors++;
                $error("FAIL rsp_wait observed=%0d expected=%0d", rsp_count, exp_count);
                finish_sim();
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic wait_high(input string tag, ref logic sig);
        int unsigned n = 0;
        while (sig !== 1'b1) begin
            n++;
            if (n > 100) begin
                checks++; errors++;
                $error("FAIL %s observed=0 expected=1", tag);
                finish_sim();
            end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        int unsigned a0, w0, n, polls;
        int unsigned lat [3][2];
        lat = '{'{0, 3}, '{3, 0}, '{2, 2}};
        cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0; cmd_wstrb = '0;
        rsp_ready = 1'b1;
        for (int i = 0; i < 8; i++) mem[i] = '0;

        // Reset state and first-cycle cmd_ready.
        repeat (3) @(posedge clk);
        #1;
        check("rst_ctrl", 64'({cmd_ready, rsp_valid, axi_awvalid, axi_wvalid, axi_bready,
                               axi_arvalid, axi_rready, rsp_timeout}), 64'h0);
        check("rst_data", 64'({rsp_rdata, rsp_resp}), 64'h0);
        check("rst_addr", 64'({axi_awaddr, axi_araddr}), 64'h0);
        rst = 1'b0;
        @(posedge clk); #1;
        check("cmd_ready_post_rst", 64'(cmd_ready), 64'h1);

        // Adder sequence.
        send(1, 32'h00, 32'd10, 1, mk(0, OKAY, 0, 1));
        send(1, 32'h04, 32'd20, 1, mk(0, OKAY, 0, 1));
        send(1, 32'h08, 32'hFFFF_FFFF, 1, mk(0, OKAY, 0, 1));
        wait_rsp();
        polls = 0;
        do begin
            send(0, 32'h0C, 0, 1, mk(0, OKAY, 0, 0));
            wait_rsp();
            polls++;
        end while (last_rdata !== 32'hFFFF_FFFF && polls < 20);
        check("poll_status", 64'(last_rdata), 64'hFFFF_FFFF);

        // Read of the sum with zero-wait latency check.
        send(0, 32'h10, 0, 1, mk(32'd30, OKAY, 0, 1));
        @(posedge clk); #1;
        check("rd_lat_e1_rsp_valid", 64'(rsp_valid), 64'h0);
        check("rd_lat_e1_rready", 64'(axi_rready), 64'h1);
        @(posedge clk); #1;
        check("rd_lat_e2_rsp_valid", 64'(rsp_valid), 64'h1);
        wait_rsp();

        // Skewed AW/W handshakes: aw first, w first, simultaneous.
        for (int i = 0; i < 3; i++) begin
            aw_lat = lat[i][0]; w_lat = lat[i][1];
            a0 = aw_hs_n; w0 = w_hs_n;
            send(1, 32'h14, 32'hA5A5_0000 + 32'(i), 1, mk(0, OKAY, 0, 1));
            wait_rsp();
            check("skew_aw_count", 64'(aw_hs_n - a0), 64'h1);
            check("skew_w_count", 64'(w_hs_n - w0), 64'h1);
        end
        aw_lat = 0; w_lat = 0;
        send(0, 32'h14, 0, 1, mk(32'hA5A5_0002, OKAY, 0, 1));
        wait_rsp();

        // Back-to-back reads with rsp_ready high.
        send(1, 32'h00, 32'h0000_FFFF, 1, mk(0, OKAY, 0, 1));
        for (int i = 0; i < 4; i++) begin
            send(0, 32'h00, 0, 1, mk(32'h0000_FFFF, OKAY, 0, 1));
            check("b2b_accept_gap", 64'(accept_cyc - last_rsp_cyc), 64'h1);
        end
        wait_rsp();

        // Response held while rsp_ready is low.
        rsp_ready = 1'b0;
        send(0, 32'h00, 0, 1, mk(32'h0000_FFFF, OKAY, 0, 1));
        wait_high("hold_rsp_valid", rsp_valid);
        for (int i = 0; i < 5; i++) begin
            check("hold_stable", 64'({rsp_valid, cmd_ready, rsp_rdata}),
                  64'({1'b1, 1'b0, 32'h0000_FFFF}));
            @(posedge clk); #1;
        end
        rsp_ready = 1'b1;
        wait_rsp();

        // Missing B response trips the watchdog after TO cycles in WR_RESP.
        b_never = 1;
        send(1, 32'h18, 32'd5, 1, mk(0, SLVERR, 1, 1));
        wait_high("wd_bready", axi_bready);
        n = 0;
        while (axi_bready === 1'b1 && n < 100) begin
            n++;
            @(posedge clk); #1;
        end
        check("wd_cycles", 64'(n), 64'(TO));
        check("wd_abort", 64'({rsp_valid, rsp_timeout, rsp_resp, axi_bready}),
              64'({1'b1, 1'b1, 2'b10, 1'b0}));
        wait_rsp();
        b_never = 0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;

        // Reset in the first cycle of RD_DATA, then a clean read.
        send(1, 32'h00, 32'd100, 1, mk(0, OKAY, 0, 1));
        send(1, 32'h04, 32'd200, 1, mk(0, OKAY, 0, 1));
        wait_rsp();
        r_lat = 5;
        send(0, 32'h10, 0, 0, mk(0, OKAY, 0, 0));
        wait_high("rd_data_entry", axi_rready);
        rst = 1'b1;
        @(posedge clk); #1;
        check("mid_rst_drop", 64'({axi_arvalid, axi_rready, rsp_valid}), 64'h0);
        rst = 1'b0;
        r_lat = 0;
        send(0, 32'h10, 0, 1, mk(32'd300, OKAY, 0, 1));
        wait_rsp();

        check("sb_drained", 64'(sb.size()), 64'h0);
        finish_sim();
    end

endmodule

// File: doc/axi_lite_master.md
# axi_lite_master

Hardware AXI4-Lite initiator that turns single-beat commands from an internal valid/ready command port into AXI4-Lite write or read transactions, and returns the response on a valid/ready response port. It sits between on-chip control logic (sequencers, self-test engines) and AXI4-Lite register slaves such as the adder peripheral. It replaces the bus-driving tasks used in simulation, so register sequences can run in the PL without the PS.

## Interface
- C_AXI_DATA_WIDTH, 32: data width of wdata/rdata; 32 only.
- C_AXI_ADDR_WIDTH, 32: address width.
- C_TIMEOUT, 1024: cycles allowed per wait state before abort; must be ≥ 2.

Ports:
- axi_aclk  in  1  single clock; all logic on its rising edge.
- axi_areset  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  block accepts a command.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  C_AXI_ADDR_WIDTH  byte address, passed unchanged.
- cmd_wdata  in  C_AXI_DATA_WIDTH  write data.
- cmd_wstrb  in  C_AXI_DATA_WIDTH/8  write strobes, passed unchanged.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer takes the response.
- rsp_rdata  out  C_AXI_DATA_WIDTH  read data; 0 for writes.
- rsp_resp  out  2  bresp or rresp; 2'b10 on timeout.
- rsp_timeout  out  1  transaction aborted by the watchdog.
- AXI4-Lite master signals:
  - axi_awaddr, axi_awvalid out; axi_awready in.
  - axi_wdata, axi_wstrb, axi_wvalid out; axi_wready in.
  - axi_bresp, axi_bvalid in; axi_bready out.
  - axi_araddr, axi_arvalid out; axi_arready in.
  - axi_rdata, axi_rresp, axi_rvalid in; axi_rready out.
  - All widths are taken from the parameters.

## Operation
- States: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_DATA, RSP.
- IDLE:
  - cmd_ready = 1.
  - On cmd_valid && cmd_ready, latch addr/wdata/wstrb.
  - Go to WR_REQ if cmd_write, else RD_REQ.
- WR_REQ:
  - Raise awvalid and wvalid together.
  - Each is dropped independently on its own handshake; flags aw_done and w_done record completion.
  - The order of the two handshakes is free.
  - When both flags are set, go to WR_RESP.
- WR_RESP:
  - bready = 1.
  - On bvalid, capture bresp, set rsp_rdata = 0, go to RSP.
- RD_REQ: arvalid = 1 until arready, then go to RD_DATA.
- RD_DATA:
  - rready = 1.
  - On rvalid, capture rdata and rresp, go to RSP.
- RSP:
  - rsp_valid = 1; rsp_* held stable until rsp_ready.
  - On rsp_ready, go to IDLE.
- Watchdog:
  - A counter clears on entry to each of WR_REQ, WR_RESP, RD_REQ and RD_DATA.
  - It increments every cycle spent in that state.
  - At C_TIMEOUT, drop all AXI valids and readies, set rsp_timeout = 1 and rsp_resp = 2'b10, and go to RSP.
  - This is a debug recovery path only; the slave must then be reset.
- Only one transaction is outstanding at any time. There is no pipelining and no address-alignment check.

## Timing
- All outputs are registered.
- Reset values:
  - All AXI valids, bready, rready, cmd_ready and rsp_valid = 0.
  - rsp_* = 0; AXI address and data outputs = 0.
  - cmd_ready rises in the first cycle after reset deasserts.
- Reset mid-transaction: next state is IDLE and every valid/ready drops on that edge. Any response already pending is discarded.
- Write latency with a zero-wait slave:
  - Command accept at edge E0; awvalid/wvalid high after E0.
  - AW/W handshake at E1; bready high after E1.
  - B handshake at E2; rsp_valid high after E2.
- Read latency: accept E0, AR handshake E1, R handshake E2, rsp_valid after E2.
- A bvalid or rvalid already high on entry to WR_RESP or RD_DATA completes on the first edge in that state.
- Back-to-back: rsp_ready at edge En returns to IDLE. The next command can be accepted at En+1.
- Valids are never dropped before their handshake, except on watchdog abort or reset.

## Structure
- Package axi_lite_pkg:
  - Response codes OKAY = 2'b00, SLVERR = 2'b10.
  - State enum.
  - Default C_TIMEOUT.
- Sub-module axi_lite_watchdog: a counter with clear, enable and an expired flag, parameterised by C_TIMEOUT.
- The FSM, the capture registers and the aw_done/w_done flags live in the top level.

## Test plan
- Against the adder slave:
  - Write 10 to 0x00, write 20 to 0x04, write 0xFFFFFFFF to 0x08.
  - Poll 0x0C until it reads 0xFFFFFFFF, then read 0x10.
  - Required: rsp_rdata = 30 and rsp_resp = 0 on every response.
- Skewed write handshakes:
  - Stub slave raises awready 3 cycles before wready: one write completes with exactly one AW and one W handshake.
  - Repeat with wready first, then with both simultaneous.
- Back-to-back traffic, rsp_ready tied high: 4 reads of 0x00 after writing 0x0000FFFF. Required: 4 responses of 0x0000FFFF, each command accepted one cycle after the previous response.
- rsp_ready held low for 5 cycles: rsp_valid and rsp_rdata stay stable; cmd_ready stays 0.
- Stub slave never raises bvalid, C_TIMEOUT = 16: after 16 cycles in WR_RESP, rsp_timeout = 1, rsp_resp = 2'b10, bready = 0.
- Assert axi_areset in cycle 1 of RD_DATA: on the next edge arvalid = rready = rsp_valid = 0. A following read of 0x10 = 300 (after 100 + 200 has been run) returns correctly.
